// File: rtl/spi_regfile_pkg.sv
// rtl/spi_regfile_pkg.sv - command field positions, FSM encodings and address helper for spi_regfile
package spi_regfile_pkg;

  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_INC_BIT  = 6;
  localparam int CMD_ADDR_MSB = 3;

  localparam logic [1:0] ST_WAIT_NCS = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_CMD      = 2'd2;
  localparam logic [1:0] ST_DATA     = 2'd3;

  // Auto-increment wraps at the last implemented register; out-of-range addresses just count on.
  function automatic logic [3:0] next_addr(input logic [3:0] addr, input logic inc,
                                           input int num_regs);
    if (!inc) return addr;
    if (addr == 4'(num_regs - 1)) return 4'd0;
    return addr + 4'd1;
  endfunction

endpackage

// File: rtl/spi_regfile_sync.sv
// rtl/spi_regfile_sync.sv - 2-FF synchroniser for the SPI pins plus sck edge strobes
module spi_regfile_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ncs,
  input  logic mosi,
  output logic mosi_out,
  output logic spi_reset,
  output logic spi_read,
  output logic spi_write
);

  logic [1:0] sck_ff;
  logic [1:0] ncs_ff;
  logic [1:0] mosi_ff;
  logic       sck_d;

  // ncs resets to "selected" so a frame already running at reset is never mistaken for a fresh select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_ff  <= 2'b00;
      ncs_ff  <= 2'b00;
      mosi_ff <= 2'b00;
      sck_d   <= 1'b0;
    end else begin
      sck_ff  <= {sck_ff[0], sck};
      ncs_ff  <= {ncs_ff[0], ncs};
      mosi_ff <= {mosi_ff[0], mosi};
      sck_d   <= sck_ff[1];
    end
  end

  assign mosi_out  = mosi_ff[1];
  assign spi_reset = ncs_ff[1];
  assign spi_read  = sck_ff[1] & ~sck_d;
  assign spi_write = ~sck_ff[1] & sck_d;

endmodule

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI mode-0 slave register file with read-only status registers
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int                  NUM_REGS  = 4,
  parameter int                  REG_W     = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [REG_W-1:0]    REG_RESET = '0,
  parameter logic [7:0]          ID_BYTE   = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sck,
  input  logic                      ncs,
  input  logic                      mosi,
  output logic                      miso,
  input  logic [NUM_REGS*REG_W-1:0] rd_data,
  output logic [NUM_REGS*REG_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]       wr_strobe,
  output logic [7:0]                cmd_q
);

  localparam int CNT_W = $clog2(REG_W + 1);

  logic mosi_s, ncs_high, sck_rise, sck_fall;

  spi_regfile_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .ncs       (ncs),
    .mosi      (mosi),
    .mosi_out  (mosi_s),
    .spi_reset (ncs_high),
    .spi_read  (sck_rise),
    .spi_write (sck_fall)
  );

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [REG_W-1:0] rx_sh, tx_sh, cap_word, rx_next, cap_rd, cap_val;
  logic             load_pend;
  logic [7:0]       cmd_r;
  logic [3:0]       addr, cap_addr;
  logic             cmd_done, word_end, cur_locked, commit;

  assign rx_next  = {rx_sh[REG_W-2:0], mosi_s};
  assign cmd_done = (state == ST_CMD) && sck_rise && (bit_cnt == CNT_W'(7));
  assign word_end = (state == ST_DATA) && sck_rise && (bit_cnt == CNT_W'(REG_W - 1));
  assign cap_addr = cmd_done ? rx_next[CMD_ADDR_MSB:0]
                             : next_addr(addr, cmd_r[CMD_INC_BIT], NUM_REGS);

  // Out-of-range addresses match no register: locked for writes, read back as zero.
  always_comb begin
    cur_locked = 1'b1;
    cap_rd     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 4'(i)) cur_locked = RO_MASK[i];
      if (cap_addr == 4'(i))
        cap_rd = RO_MASK[i] ? rd_data[i*REG_W +: REG_W] : reg_q[i*REG_W +: REG_W];
    end
  end

  assign commit  = word_end && cmd_r[CMD_WR_BIT] && !cur_locked;
  assign cap_val = (commit && cap_addr == addr) ? rx_next : cap_rd;

  // The captured word waits for the next sck fall so its MSB is not shifted away on arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT_NCS;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      cap_word  <= '0;
      load_pend <= 1'b0;
      cmd_r     <= 8'h00;
      addr      <= 4'd0;
    end else if (ncs_high) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      tx_sh     <= REG_W'(ID_BYTE) << (REG_W - 8);
      load_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_CMD;
          bit_cnt <= '0;
        end
        ST_CMD, ST_DATA: begin
          if (sck_rise) begin
            rx_sh   <= rx_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (cmd_done || word_end) begin
              bit_cnt   <= '0;
              cap_word  <= cap_val;
              load_pend <= 1'b1;
              addr      <= cap_addr;
              state     <= ST_DATA;
            end
            if (cmd_done) cmd_r <= rx_next[7:0];
          end
          if (sck_fall) begin
            if (load_pend) begin
              tx_sh     <= cap_word;
              load_pend <= 1'b0;
            end else begin
              tx_sh <= {tx_sh[REG_W-2:0], 1'b0};
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign miso  = (state == ST_CMD || state == ST_DATA) ? tx_sh[REG_W-1] : 1'b0;
  assign cmd_q = cmd_r;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_q[i*REG_W +: REG_W] = '0;
      assign wr_strobe[i]            = 1'b0;
    end else begin : g_rw
      logic [REG_W-1:0] q;
      logic             stb;
      always_ff @(posedge clk) begin
        if (rst) begin
          q   <= REG_RESET;
          stb <= 1'b0;
        end else begin
          stb <= commit && (addr == 4'(i));
          if (commit && (addr == 4'(i))) q <= rx_next;
        end
      end
      assign reg_q[i*REG_W +: REG_W] = q;
      assign wr_strobe[i]            = stb;
    end
  end

endmodule
